// File: rtl/dma_fifobram_loader_pkg.sv
// Shared types and burst-selection helpers for the DMA-to-FIFO/BRAM loader.
package dma_fifobram_loader_pkg;

    localparam int CLADDR_W = 42;
    localparam int CNT_W    = 14;
    localparam int CTRL_W   = 8;

    typedef logic [CLADDR_W-1:0] t_claddr;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        DRAIN,
        DONE
    } t_loadstate;

    localparam logic [1:0] RLEN_1 = 2'b00;
    localparam logic [1:0] RLEN_2 = 2'b01;
    localparam logic [1:0] RLEN_4 = 2'b11;

    // Largest naturally aligned burst that still fits in the remaining line count.
    function automatic logic [1:0] burst_sel(input logic [CNT_W-1:0] rem,
                                             input logic [1:0]       addr_lo);
        if (rem >= CNT_W'(4) && addr_lo == 2'b00) return RLEN_4;
        if (rem >= CNT_W'(2) && !addr_lo[0]) return RLEN_2;
        return RLEN_1;
    endfunction

    function automatic logic [2:0] burst_count(input logic [1:0] rlen);
        case (rlen)
            RLEN_4:  return 3'd4;
            RLEN_2:  return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dma_fifobram_loader.sv
// Read-side loader: issues 1/2/4-line DMA read bursts and writes the in-order
// response lines into a FIFO/BRAM write port at consecutive, wrapping addresses.
import dma_fifobram_loader_pkg::*;

module dma_fifobram_loader #(
    parameter int LOG2_DEPTH      = 9,
    parameter int MAX_OUTSTANDING = 64,
    parameter int DATA_W          = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [CLADDR_W-1:0]   start_addr_i,
    input  logic [CNT_W-1:0]      props_length_i,
    input  logic [LOG2_DEPTH-1:0] props_offset_i,
    input  logic                  props_write_fifo_i,
    input  logic                  props_write_bram_i,
    input  logic                  props_keep_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  dma_re_o,
    output logic [CLADDR_W-1:0]   dma_raddr_o,
    output logic [1:0]            dma_rlength_o,
    output logic [CTRL_W-1:0]     dma_control_o,
    input  logic                  dma_rvalid_i,
    input  logic [DATA_W-1:0]     dma_rdata_i,
    input  logic                  dma_ralmostfull_i,
    output logic                  buf_we_o,
    output logic [LOG2_DEPTH-1:0] buf_waddr_o,
    output logic [DATA_W-1:0]     buf_wdata_o,
    output logic [1:0]            buf_wfifobram_o,
    input  logic                  buf_almostfull_i
);

    localparam logic [CNT_W:0] MAX_OUT = (CNT_W+1)'(MAX_OUTSTANDING);

    t_loadstate            state_q;
    t_claddr               addr_q;
    logic [CNT_W-1:0]      len_q, issued_q, received_q, outstanding_q;
    logic [1:0]            wfb_q;
    logic [LOG2_DEPTH-1:0] wptr_q;

    logic                  re_q, we_q, busy_q, done_q;
    t_claddr               raddr_q;
    logic [1:0]            rlen_q;
    logic [LOG2_DEPTH-1:0] waddr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic [CNT_W-1:0]      rem, burst_lines;
    t_claddr               cur_addr;
    logic [1:0]            burst_len;
    logic                  issue, accept;
    logic [CNT_W-1:0]      issued_d, received_d, outstanding_d;

    always_comb begin
        rem         = len_q - issued_q;
        cur_addr    = addr_q + CLADDR_W'(issued_q);
        burst_len   = burst_sel(rem, cur_addr[1:0]);
        burst_lines = CNT_W'(burst_count(burst_len));
        // Buffer backpressure only matters when the destination is the FIFO.
        issue = (state_q == REQUEST) && (rem != '0) && !dma_ralmostfull_i
             && (!buf_almostfull_i || !wfb_q[1])
             && (({1'b0, outstanding_q} + {1'b0, burst_lines}) <= MAX_OUT);
        accept = dma_rvalid_i && (state_q == REQUEST || state_q == DRAIN);
        issued_d      = issue  ? issued_q + burst_lines : issued_q;
        received_d    = accept ? received_q + CNT_W'(1) : received_q;
        outstanding_d = outstanding_q + (issue ? burst_lines : '0)
                      - (accept ? CNT_W'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            wfb_q         <= '0;
            wptr_q        <= '0;
            re_q          <= 1'b0;
            raddr_q       <= '0;
            rlen_q        <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            re_q <= issue;
            if (issue) begin
                raddr_q <= cur_addr;
                rlen_q  <= burst_len;
            end
            we_q <= accept;
            if (accept) begin
                waddr_q <= wptr_q;
                wdata_q <= dma_rdata_i;
                wptr_q  <= wptr_q + LOG2_DEPTH'(1);
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q       <= REQUEST;
                        busy_q        <= 1'b1;
                        addr_q        <= start_addr_i;
                        len_q         <= props_length_i;
                        wfb_q         <= {props_write_fifo_i, props_write_bram_i};
                        issued_q      <= '0;
                        received_q    <= '0;
                        outstanding_q <= '0;
                        if (!props_keep_count_i) wptr_q <= props_offset_i;
                    end
                end
                REQUEST: begin
                    issued_q      <= issued_d;
                    received_q    <= received_d;
                    outstanding_q <= outstanding_d;
                    if (len_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (issued_d == len_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    received_q    <= received_d;
                    outstanding_q <= outstanding_d;
                    // The final line's write and the done pulse land in the same cycle.
                    if (received_d == len_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign dma_re_o        = re_q;
    assign dma_raddr_o     = raddr_q;
    assign dma_rlength_o   = rlen_q;
    assign dma_control_o   = '0;
    assign buf_we_o        = we_q;
    assign buf_waddr_o     = waddr_q;
    assign buf_wdata_o     = wdata_q;
    assign buf_wfifobram_o = wfb_q;

endmodule

// File: tb/tb_dma_fifobram_loader.sv
// Directed plus randomized bench for dma_fifobram_loader, checked against a
// line-level model of the request stream, responder and buffer writes.
module tb_dma_fifobram_loader;

    localparam int MAXO = 4;

    logic         clk;
    logic         reset;
    logic         start_i;
    logic [41:0]  start_addr_i;
    logic [13:0]  props_length_i;
    logic [3:0]   props_offset_i;
    logic         props_write_fifo_i, props_write_bram_i, props_keep_count_i;
    logic         busy_o, done_o, dma_re_o;
    logic [41:0]  dma_raddr_o;
    logic [1:0]   dma_rlength_o;
    logic [7:0]   dma_control_o;
    logic         dma_rvalid_i;
    logic [511:0] dma_rdata_i;
    logic         dma_ralmostfull_i;
    logic         buf_we_o;
    logic [3:0]   buf_waddr_o;
    logic [511:0] buf_wdata_o;
    logic [1:0]   buf_wfifobram_o;
    logic         buf_almostfull_i;

    dma_fifobram_loader #(.LOG2_DEPTH(4), .MAX_OUTSTANDING(MAXO), .DATA_W(512)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .start_addr_i(start_addr_i),
        .props_length_i(props_length_i), .props_offset_i(props_offset_i),
        .props_write_fifo_i(props_write_fifo_i), .props_write_bram_i(props_write_bram_i),
        .props_keep_count_i(props_keep_count_i), .busy_o(busy_o), .done_o(done_o),
        .dma_re_o(dma_re_o), .dma_raddr_o(dma_raddr_o), .dma_rlength_o(dma_rlength_o),
        .dma_control_o(dma_control_o), .dma_rvalid_i(dma_rvalid_i), .dma_rdata_i(dma_rdata_i),
        .dma_ralmostfull_i(dma_ralmostfull_i), .buf_we_o(buf_we_o), .buf_waddr_o(buf_waddr_o),
        .buf_wdata_o(buf_wdata_o), .buf_wfifobram_o(buf_wfifobram_o),
        .buf_almostfull_i(buf_almostfull_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad, cyc;
    logic [41:0]  exp_ra[$];
    int           exp_rn[$];
    int           resp_rdy[$];
    int           exp_wa[$];
    logic [511:0] exp_wd[$];
    int  req_lines, rv_cnt, rv_last_start, rv_xm2;
    int  m_len, m_wcount, m_wptr;
    logic [1:0] m_wfb;
    bit  active, busy_exp, done_exp, prev_acc, prev_raf, prev_bafblk, saw_done;
    bit  reset_hold, baf_rand;
    int  reset_at, restart_at, raf_lo, raf_hi, zero_done_cyc, dly_min, dly_max;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: check this cycle's outputs against the model, then drive inputs.
    task automatic step();
        logic [511:0] d;
        logic [41:0]  ea;
        int n, base;
        @(posedge clk); #1;
        cyc++;
        rv_xm2 = rv_last_start;
        rv_last_start = rv_cnt;
        chk("we", buf_we_o, prev_acc);
        if (buf_we_o && prev_acc && exp_wa.size() > 0) begin
            chk("waddr", buf_waddr_o, exp_wa.pop_front());
            chk("wdata", buf_wdata_o, exp_wd.pop_front());
            chk("wfifobram", buf_wfifobram_o, m_wfb);
        end
        chk("done", done_o, done_exp || cyc == zero_done_cyc);
        chk("busy", busy_o, busy_exp);
        if (done_o) saw_done = 1;
        if (prev_raf || prev_bafblk) chk("re_stall", dma_re_o, 1'b0);
        if (dma_re_o) begin
            if (exp_ra.size() == 0) chk("re_extra", 1'b1, 1'b0);
            else begin
                ea = exp_ra.pop_front();
                n  = exp_rn.pop_front();
                chk("raddr", dma_raddr_o, ea);
                chk("rlength", dma_rlength_o, (n == 4) ? 2'b11 : (n == 2) ? 2'b01 : 2'b00);
                req_lines += n;
                chk("outstanding", (req_lines - rv_xm2) <= MAXO, 1'b1);
                base = cyc + int'($urandom_range(dly_max, dly_min));
                for (int i = 0; i < n; i++) resp_rdy.push_back(base);
            end
        end
        if (done_exp || cyc == zero_done_cyc) busy_exp = 0;
        done_exp = 0;
        start_i = 1'b0;
        reset = reset_hold || (cyc == reset_at);
        if (reset) begin
            active = 0; busy_exp = 0; m_wptr = 0;
            exp_ra.delete(); exp_rn.delete();
        end
        if (cyc == restart_at) begin
            start_i = 1'b1; start_addr_i = 42'h3; props_length_i = 14'd3;
            props_offset_i = 4'd9; props_keep_count_i = 1'b0;
        end
        dma_ralmostfull_i = (cyc >= raf_lo && cyc <= raf_hi);
        buf_almostfull_i  = baf_rand ? 1'($urandom_range(1, 0)) : 1'b0;
        prev_raf    = dma_ralmostfull_i;
        prev_bafblk = buf_almostfull_i && m_wfb[1];
        prev_acc = 0;
        dma_rvalid_i = 1'b0;
        if (resp_rdy.size() > 0 && resp_rdy[0] <= cyc) begin
            void'(resp_rdy.pop_front());
            d = rand512();
            dma_rvalid_i = 1'b1;
            dma_rdata_i  = d;
            if (active) begin
                prev_acc = 1;
                exp_wa.push_back(m_wptr);
                exp_wd.push_back(d);
                m_wptr = (m_wptr + 1) % 16;
                m_wcount++;
                rv_cnt++;
                if (m_wcount == m_len) begin done_exp = 1; active = 0; end
            end
        end
    endtask

    task automatic run_cmd(input logic [41:0] a, input int len, input int off, input bit keep,
                           input bit wf, input bit wb, input int raf_rel, input int raf_n,
                           input int restart_rel, input int reset_rel);
        logic [41:0] cur;
        int rem, n, T, k;
        T = cyc;
        start_i = 1'b1; start_addr_i = a; props_length_i = 14'(len);
        props_offset_i = 4'(off); props_write_fifo_i = wf; props_write_bram_i = wb;
        props_keep_count_i = keep;
        cur = a; rem = len;
        while (rem > 0) begin
            if (rem >= 4 && cur[1:0] == 2'b00) n = 4;
            else if (rem >= 2 && cur[0] == 1'b0) n = 2;
            else n = 1;
            exp_ra.push_back(cur); exp_rn.push_back(n);
            cur = cur + 42'(n); rem -= n;
        end
        if (!keep) m_wptr = off;
        m_len = len; m_wcount = 0; m_wfb = {wf, wb}; active = (len != 0);
        busy_exp = 1; req_lines = 0; rv_cnt = 0; rv_last_start = 0; saw_done = 0;
        zero_done_cyc = (len == 0) ? T + 2 : -1;
        raf_lo = T + raf_rel; raf_hi = T + raf_rel + raf_n - 1;
        restart_at = (restart_rel > 0) ? T + restart_rel : -1;
        reset_at   = (reset_rel > 0) ? T + reset_rel : -1;
        k = 0;
        while (!saw_done && k < 400 && (reset_at < 0 || cyc <= reset_at)) begin step(); k++; end
        if (reset_at >= 0) begin
            k = 0;
            while (resp_rdy.size() > 0 && k < 200) begin step(); k++; end
            step(); step();
        end else begin
            chk("done_seen", saw_done, 1'b1);
            step();
            chk("reqs_all", exp_ra.size(), 0);
            chk("writes_all", exp_wa.size(), 0);
        end
        raf_lo = -1; raf_hi = -2;
    endtask

    initial begin
        logic [41:0] ra;
        total = 0; bad = 0; cyc = 0;
        reset_hold = 1; reset = 1'b1; start_i = 1'b0; start_addr_i = '0;
        props_length_i = '0; props_offset_i = '0; props_write_fifo_i = 1'b0;
        props_write_bram_i = 1'b0; props_keep_count_i = 1'b0;
        dma_rvalid_i = 1'b0; dma_rdata_i = '0; dma_ralmostfull_i = 1'b0; buf_almostfull_i = 1'b0;
        reset_at = -1; restart_at = -1; raf_lo = -1; raf_hi = -2; zero_done_cyc = -1;
        dly_min = 1; dly_max = 1; baf_rand = 0; m_wfb = 2'b00; m_wptr = 0;
        busy_exp = 0; done_exp = 0; prev_acc = 0; prev_raf = 0; prev_bafblk = 0; active = 0;
        req_lines = 0; rv_cnt = 0; rv_last_start = 0; rv_xm2 = 0; m_len = 0; m_wcount = 0;
        step(); step();
        reset_hold = 0;
        step(); step();
        chk("rst_re", dma_re_o, 1'b0);
        chk("rst_raddr", dma_raddr_o, 42'h0);
        chk("rst_rlength", dma_rlength_o, 2'b00);
        chk("rst_waddr", buf_waddr_o, 4'h0);
        chk("rst_wdata", buf_wdata_o, 512'h0);
        chk("rst_wfifobram", buf_wfifobram_o, 2'b00);
        chk("control", dma_control_o, 8'h0);

        run_cmd(42'h100, 8, 0, 0, 1, 0, 0, 0, 3, 0);
        run_cmd(42'h101, 7, 3, 0, 0, 1, 0, 0, 0, 0);
        run_cmd(42'h200, 12, 8, 0, 1, 1, 3, 10, 0, 0);
        dly_min = 20; dly_max = 20;
        run_cmd(42'h300, 16, 0, 0, 1, 0, 0, 0, 0, 0);
        dly_min = 1; dly_max = 3;
        run_cmd(42'h400, 4, 14, 0, 0, 1, 0, 0, 0, 0);
        run_cmd(42'h500, 2, 7, 1, 0, 1, 0, 0, 0, 0);
        run_cmd(42'h123, 0, 2, 0, 1, 0, 0, 0, 0, 0);

        baf_rand = 1; dly_min = 1; dly_max = 4;
        for (int r = 0; r < 8; r++) begin
            ra = (r == 0) ? 42'h3FF_FFFF_FFFE : {10'($urandom), 32'($urandom)};
            run_cmd(ra, (r == 0) ? 7 : int'($urandom_range(20, 1)), int'($urandom_range(15, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    0, 0, 0, 0);
        end
        baf_rand = 0;

        dly_min = 12; dly_max = 12;
        run_cmd(42'h600, 4, 5, 0, 1, 0, 0, 0, 0, 6);
        chk("post_rst_busy", busy_o, 1'b0);
        dly_min = 1; dly_max = 2;
        run_cmd(42'h700, 1, 9, 1, 1, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
